bcd_digit_extractor: RTL and testbench
======================================

BCD_DIGIT_EXTRACTOR -- requirements
Module: bcd_digit_extractor

Interface
REQ-001 Parameter WIDTH, default 16: binary input width.
REQ-002 Parameter DIVISOR, default 10: fixed radix; only 10 is supported.
REQ-003 Parameter MUL_CONST, default 6554: reciprocal constant passed to the divide stage.
REQ-004 Parameter SHIFT_CONST, default 16: reciprocal shift passed to the divide stage.
REQ-005 Parameter DIGITS, default 5: digit capacity, ceil(WIDTH*log10(2)).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  in_bin holds a value to convert.
REQ-009 in_ready  output  1  block accepts a value this cycle.
REQ-010 in_bin  input  WIDTH  unsigned binary value.
REQ-011 out_valid  output  1  out_digit holds a valid digit.
REQ-012 out_ready  input  1  sink accepts the digit this cycle.
REQ-013 out_digit  output  4  BCD digit, most significant first.
REQ-014 out_last  output  1  qualifies the final digit of the current number.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL have three states: IDLE, DIVIDE and EMIT.
REQ-017 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-018 On a transfer, the block SHALL latch in_bin into a working register, clear the digit count and enter DIVIDE.
REQ-019 In DIVIDE, each cycle SHALL compute q = floor(work/10) and r = work - 10*q, store r in the next digit slot, load work with q and increment the digit count.
REQ-020 The approximate quotient q' from the reciprocal stage SHALL be corrected to the exact value in the same cycle:
  - if the computed remainder is negative (underflow), use q'-1 and add 10 to the remainder;
  - if the remainder is 10 or more, use q'+1 and subtract 10.
REQ-021 Remainder arithmetic SHALL use WIDTH+4 signed bits.
REQ-022 DIVIDE SHALL exit to EMIT when the new quotient is 0 or the digit count reaches DIGITS; at least one digit is always produced.
REQ-023 Timing: DIVIDE lasts exactly n cycles for an n-digit value, and out_valid SHALL rise on the first cycle after DIVIDE ends.
REQ-024 In EMIT, out_valid SHALL be 1 and out_digit SHALL be the highest unsent slot; leading zeros are never produced.
REQ-025 While out_valid=1 and out_ready=0, out_digit and out_last SHALL hold stable.
REQ-026 out_last SHALL be 1 only on the least significant digit; its accepted transfer returns the block to IDLE, with in_ready=1 on the next cycle.
REQ-027 Input 0 SHALL produce the single digit 0 with out_last=1.
REQ-028 in_valid while busy SHALL be ignored, with no state change.
REQ-029 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, out_digit=0, out_last=0 and busy=0, and the work register, digit slots and digit count cleared.
REQ-031 Assertion of rst_n mid-DIVIDE or mid-EMIT SHALL abort the conversion with no further digits output.
REQ-032 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 A shared package SHALL hold the state enumeration type, the BCD digit type (4 bits) and the DIGITS derivation function.
REQ-034 The approximate divide SHALL be one sub-module instance, const_div, with WIDTH/DIVISOR/MUL_CONST/SHIFT_CONST passed through; correction, digit storage and control live in bcd_digit_extractor.

Verification
REQ-035 Input 0 with out_ready=1 -> one digit 0 with out_last=1; in_ready returns on the next cycle.
REQ-036 Input 10 -> digits 1,0; out_valid first rises 2 cycles after the transfer.
REQ-037 Input 65535 -> digits 6,5,5,3,5 after 5 DIVIDE cycles; out_last only on the 5.
REQ-038 Input 16389, a case needing reciprocal correction -> digits 1,6,3,8,9.
REQ-039 Input 1000 with out_ready toggling 1,0,0,1,... -> digits 1,0,0,0 each held while stalled, and a second in_valid during EMIT is ignored.
REQ-040 rst_n pulsed low during EMIT of 65535 -> out_valid=0 immediately; the next input 42 yields exactly 4,2.

Source files
------------

// File: rtl/bcd_digit_extractor_pkg.sv
// Shared types and helpers for the binary-to-BCD digit extractor.
package bcd_digit_extractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  // ceil(width * log10(2)) using a fixed-point approximation of log10(2)
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_extractor_const_div.sv
// Approximate divide by a constant via reciprocal multiply; also returns q'*DIVISOR
// so the caller can form and correct the remainder.
module const_div #(
  parameter int WIDTH       = 16,
  parameter int DIVISOR     = 10,
  parameter int MUL_CONST   = 6554,
  parameter int SHIFT_CONST = 16
) (
  input  logic [WIDTH-1:0] dividend_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH+3:0] prod_o
);

  localparam int PW = WIDTH + $clog2(MUL_CONST + 1);
  localparam int RW = WIDTH + 4;

  logic [PW-1:0] mult;

  assign mult   = PW'(dividend_i) * PW'(MUL_CONST);
  assign quot_o = WIDTH'(mult >> SHIFT_CONST);
  // q' may overshoot by one, so q'*DIVISOR can exceed WIDTH bits
  assign prod_o = RW'(quot_o) * RW'(DIVISOR);

endmodule

// File: rtl/bcd_digit_extractor.sv
// Serial binary-to-BCD converter: repeated divide-by-10 into digit slots, then
// streams the digits most significant first over a valid/ready handshake.
module bcd_digit_extractor
  import bcd_digit_extractor_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIVISOR     = 10,
  parameter int MUL_CONST   = 6554,
  parameter int SHIFT_CONST = 16,
  parameter int DIGITS      = bcd_digits(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic             out_last,
  output logic             busy
);

  localparam int RW = WIDTH + 4;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic signed [RW-1:0] DIV_S = RW'(DIVISOR);

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    cnt_q;
  bcd_t             digit_q [DIGITS];
  logic             out_valid_q;
  bcd_t             out_digit_q;
  logic             out_last_q;

  logic [WIDTH-1:0]     quot_approx;
  logic [RW-1:0]        quot_prod;
  logic signed [RW-1:0] rem_raw;
  logic [WIDTH-1:0]     quot_d;
  bcd_t                 digit_d;
  logic [CW-1:0]        cnt_prev;

  const_div #(
    .WIDTH      (WIDTH),
    .DIVISOR    (DIVISOR),
    .MUL_CONST  (MUL_CONST),
    .SHIFT_CONST(SHIFT_CONST)
  ) u_const_div (
    .dividend_i(work_q),
    .quot_o    (quot_approx),
    .prod_o    (quot_prod)
  );

  // Fix the reciprocal estimate by one step in either direction
  always_comb begin
    rem_raw = $signed({4'b0000, work_q}) - $signed(quot_prod);
    quot_d  = quot_approx;
    digit_d = bcd_t'(rem_raw);
    if (rem_raw < 0) begin
      quot_d  = quot_approx - WIDTH'(1);
      digit_d = bcd_t'(rem_raw + DIV_S);
    end else if (rem_raw >= DIV_S) begin
      quot_d  = quot_approx + WIDTH'(1);
      digit_d = bcd_t'(rem_raw - DIV_S);
    end
  end

  assign cnt_prev = cnt_q - CW'(1);

  // cnt_q indexes the slot being written in DIVIDE and the slot on display in EMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_digit_q <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q  <= in_bin;
            cnt_q   <= '0;
            state_q <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          digit_q[cnt_q] <= digit_d;
          work_q         <= quot_d;
          if (quot_d == '0 || cnt_q == CW'(DIGITS - 1)) begin
            state_q     <= ST_EMIT;
            out_valid_q <= 1'b1;
            out_digit_q <= digit_d;
            out_last_q  <= (cnt_q == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_digit_q <= '0;
            end else begin
              cnt_q       <= cnt_prev;
              out_digit_q <= digit_q[cnt_prev];
              out_last_q  <= (cnt_prev == '0);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_digit = out_digit_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bcd_digit_extractor.sv
// Self-checking bench: directed corner values plus random values, compared
// against a decimal-arithmetic reference model.
module tb_bcd_digit_extractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_digit;
  logic        out_last;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  bcd_digit_extractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bin   (in_bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digit(out_digit),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic convert(input int val, input int mode);
    int exp_q[$];
    int v;
    int cyc;
    int idx;
    int k;
    logic rdy;
    v = val;
    do begin
      exp_q.push_front(v % 10);
      v = v / 10;
    end while (v != 0);

    @(negedge clk);
    in_valid  = 1'b1;
    in_bin    = 16'(val);
    out_ready = 1'b0;
    check("in_ready_before", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    if (mode == 1) begin
      in_bin = 16'd7;          // must be ignored while busy
    end else begin
      in_valid = 1'b0;
    end
    check("busy_after_xfer", 32'(busy), 32'd1);

    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("divide_latency", 32'(cyc), 32'(exp_q.size()));

    idx = 0;
    k   = 0;
    while (idx < exp_q.size() && k < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_digit", 32'(out_digit), 32'(exp_q[idx]));
      check("out_last", 32'(out_last), 32'(idx == exp_q.size() - 1));
      if (mode == 1) check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      if (rdy) idx++;
      k++;
    end
    check("digits_done", 32'(idx), 32'(exp_q.size()));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    $display("convert %0d mode %0d: %0d digits", val, mode, exp_q.size());
  endtask

  initial begin
    int r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_digit", 32'(out_digit), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(0, 0);
    convert(10, 0);
    convert(65535, 0);
    convert(16389, 0);
    convert(1000, 1);

    // out_ready while idle has no effect
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_no_valid", 32'(out_valid), 32'd0);
    check("idle_ready_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // reset during EMIT of 65535 aborts the conversion
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 16'd65535;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r = 0;
    while (out_valid !== 1'b1 && r < 20) begin
      @(posedge clk); #1;
      r++;
    end
    check("abort_reached_emit", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("abort_second_digit", 32'(out_digit), 32'd5);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_digit", 32'(out_digit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    convert(42, 0);

    for (int i = 0; i < 20; i++) begin
      convert(int'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
    end
    convert(9, 2);
    convert(99999 % 65536, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
